// File: rtl/dm_stream_scheduler_pkg.sv
// Shared types and constants for the DataMover stream scheduler:
// FSM state encoding, register word map and the unmapped-read pattern.
package dm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_STS = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    localparam logic [5:0] REG_MASK      = 6'd0;
    localparam logic [5:0] REG_TIMEOUT   = 6'd1;
    localparam logic [5:0] REG_STATUS    = 6'd2;
    localparam logic [5:0] REG_CLR       = 6'd3;
    localparam logic [5:0] REG_GCNT_BASE = 6'd4;

    localparam logic [31:0] UNMAPPED_RD = 32'h5C4ED000;

    // Register word index from a byte address (word aligned, 64 words decoded).
    function automatic logic [5:0] word_idx(input logic [7:0] byte_addr);
        return byte_addr[7:2];
    endfunction

endpackage

// File: rtl/dm_stream_scheduler_if.sv
// Stream-select handshake plus set/get register bus of the scheduler.
// master = scheduler side, slave = stream command master / bus side.
interface dm_stream_scheduler_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_STREAMS_WIDTH    = 2
);
    localparam int NUM_STREAMS = 1 << C_STREAMS_WIDTH;

    logic [NUM_STREAMS-1:0]        stream_req;
    logic                          cmd_fire;
    logic                          sts_fire;
    logic [C_STREAMS_WIDTH-1:0]    stream_select;
    logic                          stream_valid;
    logic [C_S_AXI_DATA_WIDTH-1:0] set_data;
    logic [C_S_AXI_ADDR_WIDTH-1:0] set_addr;
    logic                          set_stb;
    logic [C_S_AXI_DATA_WIDTH-1:0] get_data;
    logic [C_S_AXI_ADDR_WIDTH-1:0] get_addr;
    logic                          get_stb;

    modport master (
        input  stream_req, cmd_fire, sts_fire,
        input  set_data, set_addr, set_stb, get_addr, get_stb,
        output stream_select, stream_valid, get_data
    );

    modport slave (
        output stream_req, cmd_fire, sts_fire,
        output set_data, set_addr, set_stb, get_addr, get_stb,
        input  stream_select, stream_valid, get_data
    );

endinterface

// File: rtl/dm_stream_scheduler_rr_arbiter_pick.sv
// Rotating-priority encoder: first set bit of eligible searching
// rr_ptr+1, rr_ptr+2, ... modulo 2^IDX_W (rr_ptr itself is searched last).
module rr_arbiter_pick #(
    parameter int IDX_W = 2
) (
    input  logic [(1<<IDX_W)-1:0] eligible,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic                  found,
    output logic [IDX_W-1:0]      index
);
    localparam int N = 1 << IDX_W;

    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the nearest candidate wins last.
    always_comb begin
        found = 1'b0;
        index = rr_ptr;
        cand  = rr_ptr;
        for (int k = N; k >= 1; k--) begin
            cand = rr_ptr + IDX_W'(k);
            if (eligible[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/dm_stream_scheduler.sv
// Round-robin scheduler sharing one DataMover command/status channel between
// stream queues; one outstanding transfer per grant, with mask/watchdog/counters.
module dm_stream_scheduler
    import dm_sched_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_STREAMS_WIDTH    = 2,
    parameter int C_TIMEOUT_WIDTH    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dm_stream_scheduler_if.master bus,
    output logic                  busy,
    output logic                  err
);
    localparam int NUM_STREAMS = 1 << C_STREAMS_WIDTH;
    localparam int SW          = C_STREAMS_WIDTH;
    localparam int TW          = C_TIMEOUT_WIDTH;

    state_t                  state, state_nxt;
    logic [SW-1:0]           sel_q;
    logic [SW-1:0]           rr_ptr;
    logic [NUM_STREAMS-1:0]  mask;
    logic [TW-1:0]           timeout;
    logic [TW-1:0]           wait_cnt;
    logic [31:0]             gcnt [NUM_STREAMS];
    logic                    err_q;

    logic [NUM_STREAMS-1:0]  eligible;
    logic                    pick_found;
    logic [SW-1:0]           pick_idx;
    logic                    load_grant;
    logic                    count_grant;
    logic                    timeout_hit;
    logic [5:0]              wr_idx;
    logic [5:0]              rd_idx;
    logic                    unused_bus;

    assign eligible = bus.stream_req & mask;
    assign wr_idx   = word_idx(bus.set_addr[7:0]);
    assign rd_idx   = word_idx(bus.get_addr[7:0]);

    assign unused_bus = ^{bus.get_stb, bus.set_addr, bus.get_addr, bus.set_data};

    rr_arbiter_pick #(.IDX_W(SW)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    always_comb begin
        state_nxt   = state;
        load_grant  = 1'b0;
        count_grant = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    load_grant = 1'b1;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                // A command taken in the same cycle the queue drains still counts.
                if (bus.cmd_fire) begin
                    count_grant = 1'b1;
                    state_nxt   = WAIT_STS;
                end else if (!eligible[sel_q]) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_STS: begin
                if (bus.sts_fire) begin
                    state_nxt = HOLDOFF;
                end else if ((timeout != '0) && (wait_cnt >= timeout - TW'(1))) begin
                    timeout_hit = 1'b1;
                    state_nxt   = HOLDOFF;
                end
            end
            HOLDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_q  <= '0;
            rr_ptr <= SW'(NUM_STREAMS - 1);
        end else begin
            state <= state_nxt;
            if (load_grant) begin
                sel_q  <= pick_idx;
                rr_ptr <= pick_idx;
            end
        end
    end

    // Wait counter is armed by the command handshake and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (count_grant) begin
            wait_cnt <= '0;
        end else if ((state == WAIT_STS) && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) gcnt[i] <= '0;
        end else if (count_grant) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (sel_q == SW'(i)) gcnt[i] <= gcnt[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask    <= '1;
            timeout <= '0;
            err_q   <= 1'b0;
        end else begin
            if (bus.set_stb && (wr_idx == REG_MASK))
                mask <= bus.set_data[NUM_STREAMS-1:0];
            if (bus.set_stb && (wr_idx == REG_TIMEOUT))
                timeout <= bus.set_data[TW-1:0];
            // A watchdog expiry beats a simultaneous clear.
            if (timeout_hit)
                err_q <= 1'b1;
            else if (bus.set_stb && (wr_idx == REG_CLR))
                err_q <= 1'b0;
        end
    end

    always_comb begin
        bus.get_data = C_S_AXI_DATA_WIDTH'(UNMAPPED_RD);
        case (rd_idx)
            REG_MASK: begin
                bus.get_data = '0;
                bus.get_data[NUM_STREAMS-1:0] = mask;
            end
            REG_TIMEOUT: begin
                bus.get_data = '0;
                bus.get_data[TW-1:0] = timeout;
            end
            REG_STATUS: begin
                bus.get_data = '0;
                bus.get_data[31]   = err_q;
                bus.get_data[9:8]  = state;
                bus.get_data[SW-1:0] = sel_q;
            end
            default: begin
                if ((rd_idx >= REG_GCNT_BASE) && (rd_idx < REG_GCNT_BASE + 6'(NUM_STREAMS)))
                    bus.get_data = C_S_AXI_DATA_WIDTH'(gcnt[SW'(rd_idx - REG_GCNT_BASE)]);
            end
        endcase
    end

    assign bus.stream_select = sel_q;
    assign bus.stream_valid  = (state == GRANT) || (state == WAIT_STS);
    assign busy              = (state != IDLE);
    assign err               = err_q;

endmodule
